// File: rtl/lsu_axi_fsm.sv
`default_nettype none
// ============================================================================
// lsu_axi_fsm : load/store unit with a registered AXI-lite master FSM
// Rev 1.0
// ============================================================================
module lsu_axi_fsm #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_prev_valid,
  output logic                o_this_ready,
  output logic                o_this_valid,
  input  logic                i_next_ready,
  input  logic                i_ren,
  input  logic                i_wen,
  input  logic [2:0]          i_funct3,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [XLEN-1:0]     i_st_data,
  output logic [XLEN-1:0]     o_ld_data,
  output logic [1:0]          o_err,
  output logic [ADDR_W-1:0]   o_araddr,
  output logic                o_arvalid,
  input  logic                i_arready,
  input  logic [XLEN-1:0]     i_rdata,
  input  logic [1:0]          i_rresp,
  input  logic                i_rvalid,
  output logic                o_rready,
  output logic [ADDR_W-1:0]   o_awaddr,
  output logic                o_awvalid,
  input  logic                i_awready,
  output logic [XLEN-1:0]     o_wdata,
  output logic [XLEN/8-1:0]   o_wstrb,
  output logic                o_wvalid,
  input  logic                i_wready,
  input  logic [1:0]          i_bresp,
  input  logic                i_bvalid,
  output logic                o_bready
);

  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RADDR = 3'd1,
    S_RDATA = 3'd2,
    S_WREQ  = 3'd3,
    S_WRESP = 3'd4,
    S_DONE  = 3'd5
  } t_state;

  t_state              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [2:0]          r_funct3;
  logic                r_aw_done;
  logic                r_w_done;
  logic                r_arvalid;
  logic                r_rready;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_bready;
  logic                r_this_valid;
  logic [XLEN-1:0]     r_ld_data;
  logic [1:0]          r_err;
  logic [XLEN-1:0]     r_wdata;
  logic [NB-1:0]       r_wstrb;

  logic [1:0]          w_size;
  logic                w_illegal;
  logic                w_misalign;
  logic [1:0]          w_fault;
  logic [OB-1:0]       w_in_off;
  logic [NB-1:0]       w_strb_base;
  logic [NB-1:0]       w_wstrb;
  logic [XLEN-1:0]     w_wdata;
  logic [XLEN-1:0]     w_ld_shift;
  logic [XLEN-1:0]     w_ld_ext;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_aw_ok;
  logic                w_w_ok;

  assign w_size     = i_funct3[1:0];
  assign w_in_off   = i_addr[OB-1:0];
  assign w_illegal  = (i_funct3 == 3'b111) ||
                      ((XLEN == 32) && ((w_size == 2'd3) || (i_funct3 == 3'b110)));
  assign w_wdata    = i_st_data << {w_in_off, 3'b000};
  assign w_wstrb    = w_strb_base << w_in_off;
  assign w_ld_shift = i_rdata >> {r_addr[OB-1:0], 3'b000};

  assign w_aw_hs = r_awvalid & i_awready;
  assign w_w_hs  = r_wvalid & i_wready;
  assign w_aw_ok = r_aw_done | w_aw_hs;
  assign w_w_ok  = r_w_done | w_w_hs;

  always_comb begin
    w_misalign  = 1'b0;
    w_strb_base = NB'(1);
    case (w_size)
      2'd1: begin
        w_misalign  = i_addr[0];
        w_strb_base = NB'(3);
      end
      2'd2: begin
        w_misalign  = |i_addr[1:0];
        w_strb_base = NB'(15);
      end
      2'd3: begin
        w_misalign  = |i_addr[2:0];
        w_strb_base = '1;
      end
      default: begin
        w_misalign  = 1'b0;
        w_strb_base = NB'(1);
      end
    endcase
  end

  // Faults only apply to memory ops; an illegal size outranks misalignment.
  always_comb begin
    w_fault = 2'b00;
    if (i_ren || i_wen) begin
      if (w_illegal) begin
        w_fault = 2'b11;
      end else if (w_misalign) begin
        w_fault = 2'b01;
      end
    end
  end

  always_comb begin
    w_ld_ext = w_ld_shift;
    case (r_funct3)
      3'b000:  w_ld_ext = XLEN'($signed(w_ld_shift[7:0]));
      3'b001:  w_ld_ext = XLEN'($signed(w_ld_shift[15:0]));
      3'b010:  w_ld_ext = XLEN'($signed(w_ld_shift[31:0]));
      3'b100:  w_ld_ext = XLEN'(w_ld_shift[7:0]);
      3'b101:  w_ld_ext = XLEN'(w_ld_shift[15:0]);
      3'b110:  w_ld_ext = XLEN'(w_ld_shift[31:0]);
      default: w_ld_ext = w_ld_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_funct3     <= '0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_this_valid <= 1'b0;
      r_ld_data    <= '0;
      r_err        <= 2'b00;
      r_wdata      <= '0;
      r_wstrb      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_prev_valid) begin
            r_addr    <= i_addr;
            r_funct3  <= i_funct3;
            r_wdata   <= w_wdata;
            r_wstrb   <= w_wstrb;
            r_ld_data <= '0;
            r_err     <= w_fault;
            if ((w_fault != 2'b00) || !(i_ren || i_wen)) begin
              r_this_valid <= 1'b1;
              r_state      <= S_DONE;
            end else if (i_wen) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= S_WREQ;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_RADDR;
            end
          end
        end
        S_RADDR: begin
          if (i_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (i_rvalid) begin
            r_rready     <= 1'b0;
            r_ld_data    <= w_ld_ext;
            r_err        <= (i_rresp != 2'b00) ? 2'b10 : 2'b00;
            r_this_valid <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_WREQ: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          // Both channels may complete on the same edge; the clears below win.
          if (w_aw_ok && w_w_ok) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (i_bvalid) begin
            r_bready     <= 1'b0;
            r_err        <= (i_bresp != 2'b00) ? 2'b10 : 2'b00;
            r_this_valid <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_next_ready) begin
            r_this_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_this_ready = (r_state == S_IDLE);
  assign o_this_valid = r_this_valid;
  assign o_ld_data    = r_ld_data;
  assign o_err        = r_err;
  assign o_araddr     = r_addr;
  assign o_arvalid    = r_arvalid;
  assign o_rready     = r_rready;
  assign o_awaddr     = r_addr;
  assign o_awvalid    = r_awvalid;
  assign o_wdata      = r_wdata;
  assign o_wstrb      = r_wstrb;
  assign o_wvalid     = r_wvalid;
  assign o_bready     = r_bready;

endmodule
`default_nettype wire

// File: tb/tb_lsu_axi_fsm.sv
`default_nettype none
// ============================================================================
// tb_lsu_axi_fsm : randomized bench for lsu_axi_fsm at XLEN=32 and XLEN=64
// Rev 1.0
// ============================================================================
module tb_lsu_axi_fsm;

  logic        clk;
  logic        rst;
  logic        sel64;
  logic        prev_valid;
  logic        next_ready;
  logic        ren;
  logic        wen;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [63:0] st_data;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        awready;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;

  int n_vec = 0;
  int n_err = 0;

  logic        a_this_ready, a_this_valid, a_arvalid, a_rready;
  logic        a_awvalid, a_wvalid, a_bready;
  logic [31:0] a_ld_data, a_wdata, a_araddr, a_awaddr;
  logic [3:0]  a_wstrb;
  logic [1:0]  a_err;

  logic        b_this_ready, b_this_valid, b_arvalid, b_rready;
  logic        b_awvalid, b_wvalid, b_bready;
  logic [63:0] b_ld_data, b_wdata;
  logic [31:0] b_araddr, b_awaddr;
  logic [7:0]  b_wstrb;
  logic [1:0]  b_err;

  logic        ob_this_ready, ob_this_valid, ob_arvalid, ob_rready;
  logic        ob_awvalid, ob_wvalid, ob_bready;
  logic [63:0] ob_ld_data, ob_wdata;
  logic [31:0] ob_araddr, ob_awaddr;
  logic [7:0]  ob_wstrb;
  logic [1:0]  ob_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lsu_axi_fsm #(.XLEN(32), .ADDR_W(32)) u_dut32 (
    .clk(clk), .rst(rst),
    .i_prev_valid(prev_valid & ~sel64), .o_this_ready(a_this_ready),
    .o_this_valid(a_this_valid), .i_next_ready(next_ready),
    .i_ren(ren), .i_wen(wen), .i_funct3(funct3), .i_addr(addr),
    .i_st_data(st_data[31:0]), .o_ld_data(a_ld_data), .o_err(a_err),
    .o_araddr(a_araddr), .o_arvalid(a_arvalid), .i_arready(arready),
    .i_rdata(rdata[31:0]), .i_rresp(rresp), .i_rvalid(rvalid), .o_rready(a_rready),
    .o_awaddr(a_awaddr), .o_awvalid(a_awvalid), .i_awready(awready),
    .o_wdata(a_wdata), .o_wstrb(a_wstrb), .o_wvalid(a_wvalid), .i_wready(wready),
    .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(a_bready)
  );

  lsu_axi_fsm #(.XLEN(64), .ADDR_W(32)) u_dut64 (
    .clk(clk), .rst(rst),
    .i_prev_valid(prev_valid & sel64), .o_this_ready(b_this_ready),
    .o_this_valid(b_this_valid), .i_next_ready(next_ready),
    .i_ren(ren), .i_wen(wen), .i_funct3(funct3), .i_addr(addr),
    .i_st_data(st_data), .o_ld_data(b_ld_data), .o_err(b_err),
    .o_araddr(b_araddr), .o_arvalid(b_arvalid), .i_arready(arready),
    .i_rdata(rdata), .i_rresp(rresp), .i_rvalid(rvalid), .o_rready(b_rready),
    .o_awaddr(b_awaddr), .o_awvalid(b_awvalid), .i_awready(awready),
    .o_wdata(b_wdata), .o_wstrb(b_wstrb), .o_wvalid(b_wvalid), .i_wready(wready),
    .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(b_bready)
  );

  always_comb begin
    if (sel64) begin
      ob_this_ready = b_this_ready; ob_this_valid = b_this_valid;
      ob_arvalid = b_arvalid; ob_rready = b_rready; ob_awvalid = b_awvalid;
      ob_wvalid = b_wvalid; ob_bready = b_bready; ob_ld_data = b_ld_data;
      ob_wdata = b_wdata; ob_araddr = b_araddr; ob_awaddr = b_awaddr;
      ob_wstrb = b_wstrb; ob_err = b_err;
    end else begin
      ob_this_ready = a_this_ready; ob_this_valid = a_this_valid;
      ob_arvalid = a_arvalid; ob_rready = a_rready; ob_awvalid = a_awvalid;
      ob_wvalid = a_wvalid; ob_bready = a_bready; ob_ld_data = {32'd0, a_ld_data};
      ob_wdata = {32'd0, a_wdata}; ob_araddr = a_araddr; ob_awaddr = a_awaddr;
      ob_wstrb = {4'd0, a_wstrb}; ob_err = a_err;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (xlen=%0d): got 0x%0h expected 0x%0h", tag, sel64 ? 64 : 32, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference load: pick the addressed bytes, then sign- or zero-extend to XLEN.
  function automatic logic [63:0] m_load(input logic [2:0] f3, input logic [63:0] rd,
                                         input int off, input logic [63:0] xmask);
    logic [127:0] v;
    logic [127:0] m;
    int nb;
    nb = 1 << f3[1:0];
    v  = {64'd0, rd & xmask} >> (off * 8);
    m  = (128'd1 << (nb * 8)) - 128'd1;
    v  = v & m;
    if (!f3[2] && v[nb*8-1]) v = v | ~m;
    return v[63:0] & xmask;
  endfunction

  task automatic do_op(input logic r, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [63:0] sd, input logic [63:0] rd,
                       input logic [1:0] resp, input int d1, input int d2, input int d3,
                       input int nrd);
    int          xl;
    logic [63:0] xmask;
    int          nbytes;
    int          off;
    logic [1:0]  eerr;
    logic [63:0] eld;
    int          t;
    bit          aw_ok;
    bit          w_ok;
    int          kmax;
    int          strb;
    xl     = sel64 ? 64 : 32;
    xmask  = sel64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    nbytes = 1 << f3[1:0];
    off    = int'(a % (xl / 8));
    eerr   = 2'b00;
    eld    = 64'd0;
    if (r || w) begin
      if (f3 == 3'b111 || (xl == 32 && (f3[1:0] == 2'd3 || f3 == 3'b110))) eerr = 2'b11;
      else if (a % nbytes != 0) eerr = 2'b01;
    end

    t = 0;
    while (!ob_this_ready && t < 20) begin
      tick();
      t++;
    end
    if (!ob_this_ready) begin
      check_eq("accept_timeout", ob_this_ready, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
    end

    ren = r; wen = w; funct3 = f3; addr = a; st_data = sd;
    prev_valid = 1'b1;
    tick();
    prev_valid = 1'b0;
    ren = 1'($urandom); wen = 1'($urandom); funct3 = 3'($urandom);
    addr = $urandom; st_data = {$urandom, $urandom};

    if (!(r || w) || eerr != 2'b00) begin
      check_eq("no_ar", ob_arvalid, 0);
      check_eq("no_aw", ob_awvalid, 0);
    end else if (w) begin
      aw_ok = 0;
      w_ok  = 0;
      kmax  = (d1 > d2) ? d1 : d2;
      strb  = ((1 << nbytes) - 1) << off;
      for (int k = 0; k <= kmax; k++) begin
        check_eq("awvalid", ob_awvalid, !aw_ok);
        check_eq("wvalid", ob_wvalid, !w_ok);
        check_eq("wreq_tv", ob_this_valid, 0);
        if (!aw_ok) check_eq("awaddr", ob_awaddr, a);
        if (!w_ok) begin
          check_eq("wdata", ob_wdata, (sd << (off * 8)) & xmask);
          check_eq("wstrb", ob_wstrb, 64'(strb & (sel64 ? 'hFF : 'h0F)));
        end
        awready = (k >= d1);
        wready  = (k >= d2);
        bvalid  = 1'($urandom);
        bresp   = 2'($urandom);
        tick();
        if (awready) aw_ok = 1;
        if (wready) w_ok = 1;
      end
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      for (int k = 0; k <= d3; k++) begin
        check_eq("bready", ob_bready, 1);
        check_eq("aw_w_idle", {ob_awvalid, ob_wvalid}, 0);
        check_eq("wresp_tv", ob_this_valid, 0);
        bvalid = (k == d3);
        bresp  = resp;
        tick();
      end
      bvalid = 1'b0;
      check_eq("bready_off", ob_bready, 0);
      eerr = (resp != 2'b00) ? 2'b10 : 2'b00;
    end else begin
      for (int k = 0; k <= d1; k++) begin
        check_eq("arvalid", ob_arvalid, 1);
        check_eq("araddr", ob_araddr, a);
        check_eq("raddr_rready", ob_rready, 0);
        arready = (k == d1);
        rvalid  = 1'($urandom);
        rdata   = {$urandom, $urandom};
        rresp   = 2'($urandom);
        tick();
      end
      arready = 1'b0; rvalid = 1'b0;
      for (int k = 0; k <= d2; k++) begin
        check_eq("rready", ob_rready, 1);
        check_eq("ar_idle", ob_arvalid, 0);
        check_eq("rdata_tv", ob_this_valid, 0);
        rvalid = (k == d2);
        rdata  = rd;
        rresp  = resp;
        tick();
      end
      rvalid = 1'b0;
      check_eq("rready_off", ob_rready, 0);
      eld  = m_load(f3, rd, off, xmask);
      eerr = (resp != 2'b00) ? 2'b10 : 2'b00;
    end

    check_eq("this_valid", ob_this_valid, 1);
    check_eq("ld_data", ob_ld_data, eld);
    check_eq("err", ob_err, eerr);
    for (int k = 0; k < nrd; k++) begin
      next_ready = 1'b0;
      tick();
      check_eq("hold_tv", ob_this_valid, 1);
      check_eq("hold_ready", ob_this_ready, 0);
      check_eq("hold_ld", ob_ld_data, eld);
      check_eq("hold_err", ob_err, eerr);
    end
    next_ready = 1'b1;
    tick();
    next_ready = 1'b0;
    check_eq("ret_tv", ob_this_valid, 0);
    check_eq("ret_ready", ob_this_ready, 1);
  endtask

  task automatic rand_op();
    int          kind;
    logic        r;
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [1:0]  resp;
    kind = $urandom_range(0, 9);
    r = (kind <= 4) || (kind == 8);
    w = (kind >= 5) && (kind <= 8);
    f3 = w ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
    a = $urandom;
    if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
    resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    do_op(r, w, f3, a, {$urandom, $urandom}, {$urandom, $urandom}, resp,
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 2));
  endtask

  initial begin
    rst = 1'b1; sel64 = 1'b0; prev_valid = 1'b0; next_ready = 1'b0;
    ren = 1'b0; wen = 1'b0; funct3 = 3'd0; addr = 32'd0; st_data = 64'd0;
    arready = 1'b0; rdata = 64'd0; rresp = 2'b00; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int s = 0; s < 2; s++) begin
      sel64 = s[0];
      #1;
      check_eq("rst_this_ready", ob_this_ready, 1);
      check_eq("rst_this_valid", ob_this_valid, 0);
      check_eq("rst_axi_valids", {ob_arvalid, ob_awvalid, ob_wvalid}, 0);
      check_eq("rst_axi_readys", {ob_rready, ob_bready}, 0);
      check_eq("rst_ld_data", ob_ld_data, 0);
      check_eq("rst_err", ob_err, 0);
    end

    sel64 = 1'b0;
    do_op(1, 0, 3'b000, 32'h1003, 64'd0, 64'h80FF_0000, 2'b00, 0, 0, 0, 0);
    do_op(0, 1, 3'b001, 32'h2002, 64'h1234, 64'd0, 2'b00, 3, 0, 0, 0);
    do_op(1, 0, 3'b010, 32'h3001, 64'd0, 64'd0, 2'b00, 0, 0, 0, 0);
    do_op(1, 0, 3'b011, 32'h4000, 64'd0, 64'd0, 2'b00, 0, 0, 0, 0);
    do_op(0, 1, 3'b010, 32'h0040, 64'hDEAD_BEEF, 64'd0, 2'b10, 0, 0, 1, 5);
    do_op(0, 0, 3'b010, 32'h0041, 64'd0, 64'd0, 2'b00, 0, 0, 0, 1);

    sel64 = 1'b1;
    do_op(1, 0, 3'b110, 32'h8004, 64'd0, 64'hF000_0001_0000_0000, 2'b00, 0, 0, 0, 0);
    do_op(1, 0, 3'b011, 32'h8008, 64'd0, 64'h8123_4567_89AB_CDEF, 2'b00, 1, 2, 0, 0);
    do_op(0, 1, 3'b011, 32'h0010, 64'h0102_0304_0506_0708, 64'd0, 2'b00, 0, 2, 0, 0);
    do_op(0, 1, 3'b000, 32'h0017, 64'h00AB, 64'd0, 2'b00, 1, 1, 0, 0);

    // Reset while a load sits in the data phase with no rvalid.
    sel64 = 1'b0;
    ren = 1'b1; wen = 1'b0; funct3 = 3'b010; addr = 32'h0100;
    prev_valid = 1'b1;
    tick();
    prev_valid = 1'b0;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check_eq("pre_rst_rready", ob_rready, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_rready", ob_rready, 0);
    check_eq("mid_rst_this_ready", ob_this_ready, 1);
    check_eq("mid_rst_this_valid", ob_this_valid, 0);
    check_eq("mid_rst_ld_data", ob_ld_data, 0);
    check_eq("mid_rst_arvalid", ob_arvalid, 0);

    for (int i = 0; i < 300; i++) begin
      sel64 = 1'($urandom);
      rand_op();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
